// File: rtl/hsv_colour_detect.sv
// Purpose : classify HSV pixels against a hue/sat/value window, emit a 1-bit
//           mask stream and per-frame bounding box / hit count results.
// Latency : 2 cycles pixel-in to mask-out. res_valid arrives with the eop mask beat.
// Backpressure: the pipe advances iff !mask_valid || mask_ready. in_ready mirrors that.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   h_in/s_in/v_in, in_valid,    pixel stream in. in_sop/in_eop mark the frame
//   in_ready, in_sop, in_eop     boundaries.
//   h_lo/h_hi/s_min/v_min        window. Sampled on the sop transfer.
//   mask_out/mask_valid/_ready   mask stream out
//   x_min..y_max, pix_count,     results of the last completed frame. Held until
//   res_found, res_valid         the next result. res_valid pulses for one cycle.
// Build option: define RUN_FILTER_EN to require a hit on two consecutive pixels
// of the same line. Under that option x==0 is never a hit.

module hsv_colour_detect #(
    parameter int IMAGE_W    = 640,
    parameter int IMAGE_H    = 480,
    parameter int MIN_PIXELS = 64,
    parameter int CNT_W      = 20
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [9:0]       h_in,
    input  logic [17:0]      s_in,
    input  logic [9:0]       v_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sop,
    input  logic             in_eop,
    input  logic [9:0]       h_lo,
    input  logic [9:0]       h_hi,
    input  logic [17:0]      s_min,
    input  logic [9:0]       v_min,
    output logic             mask_out,
    output logic             mask_valid,
    input  logic             mask_ready,
    output logic [10:0]      x_min,
    output logic [10:0]      x_max,
    output logic [9:0]       y_min,
    output logic [9:0]       y_max,
    output logic [CNT_W-1:0] pix_count,
    output logic             res_found,
    output logic             res_valid
);

    localparam logic [10:0]      X_LAST  = 11'(IMAGE_W - 1);
    localparam logic [9:0]       Y_LAST  = 10'(IMAGE_H - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_REQ = CNT_W'(MIN_PIXELS);

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    logic adv, xfer;
    assign adv      = !mask_valid || mask_ready;
    assign in_ready = adv;
    assign xfer     = in_valid && adv;

    // ---------------- input side: window, coordinates, frame membership
    logic [9:0]  win_h_lo, win_h_hi, win_v_min;
    logic [17:0] win_s_min;
    logic        in_frame;
    logic [10:0] x_cnt, px;
    logic [9:0]  y_cnt, py;
    logic [9:0]  eh_lo, eh_hi, ev_min;
    logic [17:0] es_min;
    logic        hue_ok, raw_pass, hit;

    // The sop pixel uses the live window; the rest of the frame uses the copy.
    assign eh_lo  = in_sop ? h_lo  : win_h_lo;
    assign eh_hi  = in_sop ? h_hi  : win_h_hi;
    assign es_min = in_sop ? s_min : win_s_min;
    assign ev_min = in_sop ? v_min : win_v_min;
    assign px     = in_sop ? 11'd0 : x_cnt;
    assign py     = in_sop ? 10'd0 : y_cnt;

    // h_lo > h_hi describes a window that wraps through 0 (reds).
    assign hue_ok   = (eh_lo <= eh_hi) ? (h_in >= eh_lo && h_in <= eh_hi)
                                       : (h_in >= eh_lo || h_in <= eh_hi);
    assign raw_pass = hue_ok && (s_in >= es_min) && (v_in >= ev_min);

`ifdef RUN_FILTER_EN
    logic prev_pass;
    assign hit = raw_pass && prev_pass && (px != 11'd0);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  prev_pass <= 1'b0;
        else if (xfer) prev_pass <= raw_pass;
    end
`else
    assign hit = raw_pass;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win_h_lo  <= '0;
            win_h_hi  <= '0;
            win_s_min <= '0;
            win_v_min <= '0;
            in_frame  <= 1'b0;
            x_cnt     <= '0;
            y_cnt     <= '0;
        end else if (xfer) begin
            if (in_sop) begin
                win_h_lo  <= h_lo;
                win_h_hi  <= h_hi;
                win_s_min <= s_min;
                win_v_min <= v_min;
            end
            in_frame <= !in_eop && (in_sop || in_frame);
            if (px == X_LAST) begin
                x_cnt <= '0;
                y_cnt <= (py == Y_LAST) ? py : py + 10'd1;
            end else begin
                x_cnt <= px + 11'd1;
                y_cnt <= py;
            end
        end
    end

    // ---------------- S1 / S2 pipeline
    logic        s1_vld, s1_hit, s1_sop, s1_eop, s1_frm;
    logic [10:0] s1_x;
    logic [9:0]  s1_y;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_vld     <= 1'b0;
            s1_hit     <= 1'b0;
            s1_sop     <= 1'b0;
            s1_eop     <= 1'b0;
            s1_frm     <= 1'b0;
            s1_x       <= '0;
            s1_y       <= '0;
            mask_valid <= 1'b0;
            mask_out   <= 1'b0;
        end else if (adv) begin
            s1_vld <= in_valid;
            if (in_valid) begin
                // Pixels outside a frame never produce a hit.
                s1_frm <= in_sop || in_frame;
                s1_hit <= hit && (in_sop || in_frame);
                s1_sop <= in_sop;
                s1_eop <= in_eop;
                s1_x   <= px;
                s1_y   <= py;
            end
            mask_valid <= s1_vld;
            mask_out   <= s1_vld && s1_hit;
        end
    end

    // ---------------- accumulation as a frame pixel enters S2
    logic             acc_en, frame_end;
    logic [10:0]      acc_xmin, acc_xmax, nx_xmin, nx_xmax;
    logic [9:0]       acc_ymin, acc_ymax, nx_ymin, nx_ymax;
    logic [CNT_W-1:0] acc_cnt, nx_cnt;
    logic             nx_found;
    state_t           state_q, state_nxt;

    assign acc_en = adv && s1_vld && s1_frm;

    always_comb begin
        // A sop pixel starts from fresh accumulators, discarding any partial frame.
        nx_xmin = s1_sop ? '1 : acc_xmin;
        nx_xmax = s1_sop ? '0 : acc_xmax;
        nx_ymin = s1_sop ? '1 : acc_ymin;
        nx_ymax = s1_sop ? '0 : acc_ymax;
        nx_cnt  = s1_sop ? '0 : acc_cnt;
        if (s1_hit) begin
            if (s1_x < nx_xmin) nx_xmin = s1_x;
            if (s1_x > nx_xmax) nx_xmax = s1_x;
            if (s1_y < nx_ymin) nx_ymin = s1_y;
            if (s1_y > nx_ymax) nx_ymax = s1_y;
            if (nx_cnt != CNT_MAX) nx_cnt = nx_cnt + 1'b1;
        end
        nx_found = (nx_cnt >= CNT_REQ);
    end

    assign frame_end = acc_en && s1_eop && (s1_sop || state_q == ACTIVE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_xmin  <= '0;
            acc_xmax  <= '0;
            acc_ymin  <= '0;
            acc_ymax  <= '0;
            acc_cnt   <= '0;
            x_min     <= '0;
            x_max     <= '0;
            y_min     <= '0;
            y_max     <= '0;
            pix_count <= '0;
            res_found <= 1'b0;
        end else begin
            if (acc_en) begin
                acc_xmin <= nx_xmin;
                acc_xmax <= nx_xmax;
                acc_ymin <= nx_ymin;
                acc_ymax <= nx_ymax;
                acc_cnt  <= nx_cnt;
            end
            // Results are latched as the FSM enters DONE so that they are
            // already stable while res_valid is high.
            if (frame_end) begin
                pix_count <= nx_cnt;
                res_found <= nx_found;
                x_min     <= nx_found ? nx_xmin : '0;
                x_max     <= nx_found ? nx_xmax : '0;
                y_min     <= nx_found ? nx_ymin : '0;
                y_max     <= nx_found ? nx_ymax : '0;
            end
        end
    end

    // ---------------- frame FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        res_valid = 1'b0;
        if (state_q == DONE) begin
            res_valid = 1'b1;
            state_nxt = IDLE;
        end
        if (acc_en && s1_sop)  state_nxt = s1_eop ? DONE : ACTIVE;
        else if (frame_end)    state_nxt = DONE;
    end

endmodule

// File: tb/tb_hsv_colour_detect.sv
module tb_hsv_colour_detect;

    localparam int W    = 8;
    localparam int H    = 4;
    localparam int MINP = 2;
    localparam int CW   = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [9:0]    h_in = '0, v_in = '0, h_lo = '0, h_hi = '0, v_min = '0;
    logic [17:0]   s_in = '0, s_min = '0;
    logic          in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
    logic          in_ready, mask_out, mask_valid, res_found, res_valid;
    logic          mask_ready;
    logic [10:0]   x_min, x_max;
    logic [9:0]    y_min, y_max;
    logic [CW-1:0] pix_count;

    hsv_colour_detect #(.IMAGE_W(W), .IMAGE_H(H), .MIN_PIXELS(MINP), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .h_in(h_in), .s_in(s_in), .v_in(v_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop), .in_eop(in_eop),
        .h_lo(h_lo), .h_hi(h_hi), .s_min(s_min), .v_min(v_min),
        .mask_out(mask_out), .mask_valid(mask_valid), .mask_ready(mask_ready),
        .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
        .pix_count(pix_count), .res_found(res_found), .res_valid(res_valid));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0, bad = 0;

    task automatic check(string name, longint act, longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model and scoreboard queues
    typedef struct {
        int cnt; bit found; int xmin, xmax, ymin, ymax; int eop_cyc; bit lat_chk;
    } res_t;

    bit   mq[$];
    res_t rq[$];
    bit   m_inframe = 0;
    int   m_x = 0, m_y = 0;
    int   w_hlo, w_hhi, w_smin, w_vmin;
    int   hx[$], hy[$];
`ifdef RUN_FILTER_EN
    bit   m_prev = 0;
`endif
    bit   lat_mode = 1;
    bit   rand_rdy = 0;
    int   stall_from = -100;

    function automatic bit in_win(int h, int s, int v, int lo, int hi, int smin, int vmin);
        bit hue;
        if (lo <= hi) hue = (h >= lo) && (h <= hi);
        else          hue = (h >= lo) || (h <= hi);
        return hue && (s >= smin) && (v >= vmin);
    endfunction

    task automatic model_push(int h, int s, int v, bit sop, bit eop);
        bit raw, hit, frm;
        res_t r;
        if (sop) begin
            w_hlo = int'(h_lo); w_hhi = int'(h_hi); w_smin = int'(s_min); w_vmin = int'(v_min);
            m_x = 0; m_y = 0; m_inframe = 1;
            hx.delete(); hy.delete();
        end
        raw = in_win(h, s, v, w_hlo, w_hhi, w_smin, w_vmin);
`ifdef RUN_FILTER_EN
        hit = raw && m_prev && (m_x != 0);
        m_prev = raw;
`else
        hit = raw;
`endif
        frm = m_inframe;
        mq.push_back(frm && hit);
        if (frm && hit) begin hx.push_back(m_x); hy.push_back(m_y); end
        if (m_x == W - 1) begin m_x = 0; if (m_y < H - 1) m_y++; end
        else m_x++;
        if (frm && eop) begin
            r.cnt = (hx.size() > (2**CW - 1)) ? (2**CW - 1) : hx.size();
            r.found = (r.cnt >= MINP);
            r.xmin = 0; r.xmax = 0; r.ymin = 0; r.ymax = 0;
            if (r.found) begin
                r.xmin = 9999; r.ymin = 9999;
                foreach (hx[i]) begin
                    if (hx[i] < r.xmin) r.xmin = hx[i];
                    if (hx[i] > r.xmax) r.xmax = hx[i];
                    if (hy[i] < r.ymin) r.ymin = hy[i];
                    if (hy[i] > r.ymax) r.ymax = hy[i];
                end
            end
            r.eop_cyc = cyc;
            r.lat_chk = lat_mode;
            rq.push_back(r);
            m_inframe = 0;
        end
    endtask

    // ---------------- driver
    task automatic send(int h, int s, int v, bit sop, bit eop);
        bit acc = 0;
        h_in = 10'(h); s_in = 18'(s); v_in = 10'(v);
        in_sop = sop; in_eop = eop; in_valid = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1;
                model_push(h, s, v, sop, eop);
            end
            @(posedge clk); #2;
        end
        if (!acc) check("input_accept_timeout", acc, 1);
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    endtask

    task automatic set_win(int lo, int hi, int smn, int vmn);
        h_lo = 10'(lo); h_hi = 10'(hi); s_min = 18'(smn); v_min = 10'(vmn);
    endtask

    task automatic check_idle(string tag);
        check({tag, "_mask_valid"}, mask_valid, 0);
        check({tag, "_mask_out"},   mask_out,   0);
        check({tag, "_res_valid"},  res_valid,  0);
        check({tag, "_res_found"},  res_found,  0);
        check({tag, "_pix_count"},  pix_count,  0);
        check({tag, "_bbox"},       {x_min, x_max, y_min, y_max}, 0);
        check({tag, "_in_ready"},   in_ready,   1);
    endtask

    // ---------------- downstream ready generator
    initial begin
        mask_ready = 1'b1;
        forever begin
            @(posedge clk); #2;
            if (cyc >= stall_from && cyc < stall_from + 5) mask_ready = 1'b0;
            else if (rand_rdy) mask_ready = ($urandom_range(0, 3) != 0);
            else mask_ready = 1'b1;
        end
    end

    // ---------------- monitor
    initial begin
        res_t r;
        bit   e;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                check("in_ready_rule", in_ready, (!mask_valid || mask_ready));
                if (mask_valid && mask_ready) begin
                    if (mq.size() == 0) check("mask_unexpected", mask_valid, 0);
                    else begin
                        e = mq.pop_front();
                        check("mask", mask_out, e);
                    end
                end
                if (res_valid) begin
                    if (rq.size() == 0) check("res_unexpected", res_valid, 0);
                    else begin
                        r = rq.pop_front();
                        check("res_count", pix_count, r.cnt);
                        check("res_found", res_found, r.found);
                        check("res_x_min", x_min, r.xmin);
                        check("res_x_max", x_max, r.xmax);
                        check("res_y_min", y_min, r.ymin);
                        check("res_y_max", y_max, r.ymax);
                        if (r.lat_chk) check("res_latency", cyc - r.eop_cyc, 2);
                    end
                end
            end
        end
    end

    localparam int HH = 340, HS = 600, HV = 500;   // hit for the 300..380 window

    // ---------------- stimulus
    initial begin
        int n, idx;
        bit hp;
        @(negedge clk);
        check_idle("reset");
        @(posedge clk); #2;
        reset_n = 1'b1;
        @(posedge clk); #2;

        // 8x4 frame with hits at (2,1) and (5,3)
        set_win(300, 380, 512, 200);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                idx = y * W + x;
                hp = (x == 2 && y == 1) || (x == 5 && y == 3);
                send(hp ? HH : 100, HS, HV, idx == 0, idx == W * H - 1);
            end
        // pixels after eop are outside any frame
        send(HH, HS, HV, 0, 0);
        send(HH, HS, HV, 0, 1);

        // wrapping hue window
        set_win(1000, 20, 512, 200);
        send(1010, HS, HV, 1, 0);
        send(10,   HS, HV, 0, 0);
        send(500,  HS, HV, 0, 0);
        send(20,   HS, HV, 0, 0);
        send(21,   HS, HV, 0, 0);
        send(1019, HS, HV, 0, 0);
        send(0,    HS, 100, 0, 1);

        // downstream stall mid-line
        lat_mode = 0;
        set_win(300, 380, 512, 200);
        for (int i = 0; i < 16; i++) begin
            if (i == 4) stall_from = cyc + 1;
            send((i % 3 != 0) ? HH : 100, HS, HV, i == 0, i == 15);
        end
        repeat (4) @(posedge clk);
        #2;
        lat_mode = 1;

        // aborted frame followed by a complete one
        for (int i = 0; i < 10; i++) send((i % 2) ? HH : 700, HS, HV, i == 0, 0);
        for (int i = 0; i < W * H; i++) send((i == 9 || i == 10 || i == 27) ? HH : 700, HS, HV, i == 0, i == W * H - 1);

        // single hit: below MIN_PIXELS
        for (int i = 0; i < W * H; i++) send((i == 19) ? HH : 700, HS, HV, i == 0, i == W * H - 1);

        // 1-pixel frame, then an all-hit 40-pixel frame (count saturates, y saturates)
        send(HH, HS, HV, 1, 1);
        for (int i = 0; i < 40; i++) send(HH, HS, HV, i == 0, i == 39);

        // reset mid-frame, then a fresh frame
        for (int i = 0; i < 12; i++) send(HH, HS, HV, i == 0, 0);
        reset_n = 1'b0;
        mq.delete(); rq.delete(); m_inframe = 0;
`ifdef RUN_FILTER_EN
        m_prev = 0;
`endif
        repeat (2) begin @(negedge clk); check_idle("midreset"); end
        @(posedge clk); #2;
        reset_n = 1'b1;
        for (int i = 0; i < W * H; i++) send((i == 12 || i == 13 || i == 30) ? HH : 100, HS, HV, i == 0, i == W * H - 1);

        // randomized frames with random window, window changes after sop, random ready
        lat_mode = 0;
        rand_rdy = 1;
        for (int f = 0; f < 8; f++) begin
            set_win($urandom_range(0, 1019), $urandom_range(0, 1019), $urandom_range(0, 1024), $urandom_range(0, 1020));
            n = $urandom_range(1, 40);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 1) == 1)
                    send(int'(h_lo), 1024, 1020, i == 0, i == n - 1);
                else
                    send($urandom_range(0, 1019), $urandom_range(0, 1024), $urandom_range(0, 1020), i == 0, i == n - 1);
                if (i == 0) set_win($urandom_range(0, 1019), $urandom_range(0, 1019), $urandom_range(0, 1024), $urandom_range(0, 1020));
            end
            if ($urandom_range(0, 1) == 1) send($urandom_range(0, 1019), 1024, 1020, 0, 0);
        end

        rand_rdy = 0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("mask_queue_drained", mq.size(), 0);
        check("res_queue_drained", rq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
